seg7_scan_driver: RTL and testbench

- Downstream consumer of the processor's 16-bit test value.
- Displays it as four hex digits on a common-anode, time-multiplexed 7-segment display (board I/O stage).
- Contains a refresh prescaler, a digit-scan counter, and a frame-synchronous shadow register so a digit never tears mid-frame.
- Outputs are registered and drive the FPGA pins directly.

---
 rtl/seg7_pkg.sv | 10 +
 rtl/seg7_scan_driver_hex_to_seg7.sv | 9 +
 rtl/seg7_scan_driver.sv | 56 +++++
 tb/tb_seg7_scan_driver.sv | 111 +++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants and hex segment table for 7-segment display drivers
package seg7_pkg;
  localparam int NUM_DIGITS = 4;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] AN_OFF = 4'hF;
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
endpackage

// File: rtl/seg7_scan_driver_hex_to_seg7.sv
// hex_to_seg7: combinational hex nibble to active-low {g,f,e,d,c,b,a} encoder
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);
  assign seg = SEG_TABLE[nibble];
endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed 4-digit hex display with frame-synchronous shadow register
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter bit LEAD_ZERO_BLANK = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] value,
  input  logic        hold,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);
  localparam int PW = $clog2(REFRESH_DIV);
  localparam int DW = $clog2(NUM_DIGITS);
  logic [PW-1:0] pre;
  logic [DW-1:0] digit;
  logic [15:0]   shadow;
  logic          frame_start, first;
  logic [6:0]    code;
  logic          tc, blank;
  assign tc = pre == PW'(REFRESH_DIV - 1);
  // a digit is blank when it and every more-significant nibble is zero
  assign blank = LEAD_ZERO_BLANK && digit != '0 && (shadow >> {digit, 2'b00}) == 16'h0;
  hex_to_seg7 u_enc (.nibble(shadow[{digit, 2'b00} +: 4]), .seg(code));
  always_ff @(posedge clk) begin
    if (reset) begin
      an <= AN_OFF;
      seg <= SEG_BLANK;
      dp <= 1'b1;
      pre <= '0;
      digit <= '0;
      shadow <= 16'h0;
      frame_start <= 1'b1;
      first <= 1'b1;
    end else begin
      dp <= 1'b1;
      if (frame_start && (first || !hold)) shadow <= value;
      // first edge after reset only loads the shadow; scan starts on the next edge
      if (first) begin
        first <= 1'b0;
        frame_start <= 1'b0;
        an <= AN_OFF;
        seg <= SEG_BLANK;
      end else begin
        pre <= tc ? '0 : pre + 1'b1;
        if (tc) digit <= digit + 1'b1;
        frame_start <= tc && digit == DW'(NUM_DIGITS - 1);
        an <= blank ? AN_OFF : ~(4'b1 << digit);
        seg <= blank ? SEG_BLANK : code;
      end
    end
  end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: scoreboard bench comparing two display variants against a frame-timing model
module tb_seg7_scan_driver;
  localparam int R = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [15:0] value = 16'h1234;
  logic hold = 1'b0;
  logic [3:0] an0, an1;
  logic [6:0] seg0, seg1;
  logic dp0, dp1;
  int errors = 0;
  int checks = 0;
  int t = 0;
  logic [15:0] msh = 16'h0;
  typedef struct { logic [10:0] e0; logic [10:0] e1; } exp_t;
  exp_t sb [$];
  logic [6:0] tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  always #5 clk = ~clk;

  seg7_scan_driver #(.REFRESH_DIV(R), .LEAD_ZERO_BLANK(1'b0)) u0 (
    .clk(clk), .reset(reset), .value(value), .hold(hold), .an(an0), .seg(seg0), .dp(dp0));
  seg7_scan_driver #(.REFRESH_DIV(R), .LEAD_ZERO_BLANK(1'b1)) u1 (
    .clk(clk), .reset(reset), .value(value), .hold(hold), .an(an1), .seg(seg1), .dp(dp1));

  function automatic logic [10:0] model(bit lzb, int tt, logic [15:0] sh);
    int d;
    logic [3:0] nib;
    logic [3:0] one;
    if (tt == 0) return {4'hF, 7'h7F};
    d = ((tt - 1) / R) % 4;
    nib = sh[d*4 +: 4];
    if (lzb && d != 0 && (sh >> (4 * d)) == 16'h0) return {4'hF, 7'h7F};
    one = 4'b1;
    return {~(one << d), tbl[nib]};
  endfunction

  task automatic check(input string tag, input logic [10:0] obs, input logic [10:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s t=%0d an/seg got %h/%h expected %h/%h", tag, t, obs[10:7], obs[6:0], exp[10:7], exp[6:0]);
    end
  endtask

  task automatic tick();
    exp_t e;
    if (reset) begin
      e.e0 = {4'hF, 7'h7F};
      e.e1 = {4'hF, 7'h7F};
      msh = 16'h0;
      t = 0;
    end else begin
      e.e0 = model(1'b0, t, msh);
      e.e1 = model(1'b1, t, msh);
      if (t == 0 || (t % (4 * R) == 1 && !hold)) msh = value;
      t++;
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("plain", {an0, seg0}, e.e0);
    check("lzb", {an1, seg1}, e.e1);
    checks++;
    assert ({dp0, dp1} === 2'b11) else begin
      errors++;
      $error("FAIL dp got %b expected 11", {dp0, dp1});
    end
  endtask

  initial begin
    hold = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    repeat (42) tick();
    hold = 1'b0;
    value = 16'hFEDC;
    repeat (32) tick();
    value = 16'hBA98;
    repeat (32) tick();
    while (t % (4 * R) != 1) tick();
    value = 16'h1111;
    repeat (16) tick();
    repeat (6) tick();
    value = 16'h2222;
    repeat (26) tick();
    while (t % (4 * R) != 0) tick();
    hold = 1'b1;
    value = 16'hABCD;
    repeat (8) tick();
    hold = 1'b0;
    repeat (36) tick();
    value = 16'h0050;
    repeat (36) tick();
    value = 16'h0000;
    repeat (36) tick();
    value = 16'h1234;
    repeat (20) tick();
    while (((t - 1) / R) % 4 != 2) tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    value = 16'h9A0C;
    repeat (40) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
